pipeline_register_elastic: RTL and testbench

- Parametrised elastic pipeline register. Successor to the fixed-field stall/invalid stage registers between the RV32E pipeline stages (EX, MEMPREP, ...).
- Carries an arbitrary-width payload plus a separate side-effect mask (regfile write enables and similar) across one stage boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is driven purely from a register.
- Supports flush, and kill of side effects for invalid beats.

---
 rtl/pipeline_register_elastic.sv | 131 +++++++++++++
 tb/tb_pipeline_register_elastic.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_register_elastic.sv
// Elastic pipeline register: 2-entry skid buffer, flush, side-effect kill.
// Optional stall counter enabled by defining PIPE_STALL_COUNT_EN.
module pipeline_register_elastic #(
    parameter int DATA_WIDTH = 36,
    parameter int SE_WIDTH   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_kill,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SE_WIDTH-1:0]   in_se,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SE_WIDTH-1:0]   out_se,
    output logic [31:0]           stall_count
);

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
    logic [SE_WIDTH-1:0]   m_se_q, m_se_d;
    logic [SE_WIDTH-1:0]   s_se_q, s_se_d;
    logic                  in_ready_q, in_ready_d;
    logic                  accept, consume;
    logic [SE_WIDTH-1:0]   se_in;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_data_q;
    assign out_se    = m_se_q & {SE_WIDTH{out_valid}};

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid & out_ready;
    assign se_in   = in_kill ? '0 : in_se;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_se_d   = m_se_q;
        s_data_d = s_data_q;
        s_se_d   = s_se_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_data_d = in_data;
                    m_se_d   = se_in;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (accept && consume) begin
                    m_data_d = in_data;
                    m_se_d   = se_in;
                end else if (accept) begin
                    s_data_d = in_data;
                    s_se_d   = se_in;
                    state_d  = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    m_data_d = s_data_q;
                    m_se_d   = s_se_q;
                    s_data_d = '0;
                    s_se_d   = '0;
                    state_d  = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush keeps the last payload visible so out_data never goes X.
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = m_data_q;
            m_se_d   = m_se_q;
            s_data_d = '0;
            s_se_d   = '0;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            m_data_q   <= '0;
            m_se_q     <= '0;
            s_data_q   <= '0;
            s_se_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_se_q     <= m_se_d;
            s_data_q   <= s_data_d;
            s_se_q     <= s_se_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef PIPE_STALL_COUNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_register_elastic.sv
// Bench for pipeline_register_elastic: FIFO-of-beats model plus directed vectors.
module tb_pipeline_register_elastic;

    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_kill, out_ready;
    logic [DW-1:0] in_data;
    logic          in_se;
    logic          in_ready, out_valid, out_se;
    logic [DW-1:0] out_data;
    logic [31:0]   stall_count;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pipeline_register_elastic #(.DATA_WIDTH(DW), .SE_WIDTH(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kill(in_kill),
        .in_data(in_data), .in_se(in_se),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_se(out_se),
        .stall_count(stall_count)
    );

    // Model: queue of beats in flight; capacity 2.
    typedef struct packed {
        logic [DW-1:0] d;
        logic          se;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] m_last = '0;
    logic [31:0]   m_stall = '0;

    always @(posedge clk) begin
        bit acc, cons;
        if (!rst_n) begin
            q.delete();
            m_last  = '0;
            m_stall = '0;
        end else begin
            acc  = in_valid && (q.size() < 2);
            cons = (q.size() > 0) && out_ready;
`ifdef PIPE_STALL_COUNT_EN
            if (q.size() > 0 && !out_ready && !flush && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;
`endif
            if (cons) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back('{d: in_data, se: in_kill ? 1'b0 : in_se});
            if (q.size() > 0) m_last = q[0].d;
        end
        started = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("out_data", 64'(out_data), 64'(m_last));
            chk("out_se", 64'(out_se), 64'(q.size() > 0 ? q[0].se : 1'b0));
            chk("stall_count", 64'(stall_count), 64'(m_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic se, input logic k,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_se     = se;
        in_kill   = k;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, '0, 0, 0, 0, 0);
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;

        // 1: single beat, one-cycle latency
        drive(1, 36'h5_DEADBEEF, 1, 0, 1, 0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'h5_DEADBEEF);
        chk("t1_se", 64'(out_se), 64'd1);
        drive(0, '0, 0, 0, 1, 0);
        tick();
        chk("t1_drain", 64'(out_valid), 64'd0);

        // 2: fill skid, refuse C, drain in order
        drive(1, 36'h1, 1, 0, 0, 0);
        tick();
        drive(1, 36'h2, 1, 0, 0, 0);
        tick();
        chk("t2_full_ready", 64'(in_ready), 64'd0);
        drive(1, 36'h3, 1, 0, 0, 0);
        tick();
        chk("t2_A", 64'(out_data), 64'h1);
        drive(0, '0, 0, 0, 1, 0);
        tick();
        chk("t2_B", 64'(out_data), 64'h2);
        chk("t2_B_ready", 64'(in_ready), 64'd1);
        tick();
        chk("t2_empty", 64'(out_valid), 64'd0);
        chk("t2_hold_data", 64'(out_data), 64'h2);

        // 3: killed beat
        drive(1, 36'h7, 1, 1, 0, 0);
        tick();
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_data", 64'(out_data), 64'h7);
        chk("t3_se", 64'(out_se), 64'd0);
        drive(0, '0, 0, 0, 1, 0);
        tick();

        // 4: flush while FULL with in_valid
        drive(1, 36'hA, 1, 0, 0, 0);
        tick();
        drive(1, 36'hB, 1, 0, 0, 0);
        tick();
        drive(1, 36'hC, 1, 0, 0, 1);
        tick();
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_se", 64'(out_se), 64'd0);
        chk("t4_ready", 64'(in_ready), 64'd1);
        drive(0, '0, 0, 0, 1, 0);
        tick();
        chk("t4_no_C", 64'(out_valid), 64'd0);

        // 5: reset while FULL, then flush+valid on release
        drive(1, 36'h11, 1, 0, 0, 0);
        tick();
        drive(1, 36'h12, 1, 0, 0, 0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_data", 64'(out_data), 64'd0);
        chk("t5_ready", 64'(in_ready), 64'd1);
        chk("t5_stall", 64'(stall_count), 64'd0);
        rst_n = 1'b1;
        drive(1, 36'h13, 1, 0, 0, 1);
        tick();
        chk("t5_flush_empty", 64'(out_valid), 64'd0);

        // 6: stall counter over 10 held cycles, flush on the last
        do_reset();
        drive(1, 36'h21, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, '0, 0, 0, 0, i == 9);
            tick();
        end
`ifdef PIPE_STALL_COUNT_EN
        chk("t6_stall", 64'(stall_count), 64'd9);
`else
        chk("t6_stall", 64'(stall_count), 64'd0);
`endif

        // Mixed traffic pattern
        for (int i = 0; i < 60; i++) begin
            drive(logic'((i % 3) != 1), DW'(i * 36'h1_0000_0101),
                  logic'(i[0]), logic'((i % 7) == 3),
                  logic'((i % 4) != 2), logic'((i % 23) == 17));
            tick();
        end
        drive(0, '0, 0, 0, 1, 0);
        tick();
        tick();
        chk("end_drained", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
